// File: rtl/wb_stage.sv
// Registered writeback stage: selects load/ALU/PC+4/aux, formats RISC-V loads,
// and waits (bounded by TIMEOUT) for a late load response before writing rd.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int AUX_EN  = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_wb_sel,
    input  logic            i_rd_wren,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic [XLEN-1:0] i_pc_four,
    input  logic [XLEN-1:0] i_aux_data,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_addr_lo,
    input  logic            i_ld_valid,
    input  logic [XLEN-1:0] i_ld_data,
    output logic            o_rd_wren,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_ld_timeout,
    output logic            o_dbg_state
);

    // Handshake: an instruction transfers on a rising edge where i_valid && o_ready;
    // o_ready is high only in IDLE and never depends on i_valid.
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WAIT_LD = 1'b1
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_cnt;
    logic            r_ld_wren;
    logic [4:0]      r_ld_rd_addr;
    logic [2:0]      r_ld_funct3;
    logic [1:0]      r_ld_lo;

    logic            w_accept;
    logic            w_commit;
    logic            w_wren;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_timeout;
    logic            w_latch;
    logic [2:0]      w_funct3;
    logic [1:0]      w_lo;
    logic [XLEN-1:0] w_ld_fmt;
    logic [XLEN-1:0] w_src;

    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
            3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
            3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
            3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign o_ready     = (r_state == S_IDLE);
    assign o_dbg_state = (r_state == S_WAIT_LD);
    assign w_accept    = i_valid && o_ready;

    // While waiting, the instruction's own fields come from the latched copies.
    assign w_funct3 = (r_state == S_WAIT_LD) ? r_ld_funct3 : i_ld_funct3;
    assign w_lo     = (r_state == S_WAIT_LD) ? r_ld_lo     : i_ld_addr_lo;
    assign w_ld_fmt = fmt_load(i_ld_data, w_funct3, w_lo);

    always_comb begin
        w_src = i_alu_data;
        case (i_wb_sel)
            2'b00:   w_src = w_ld_fmt;
            2'b01:   w_src = i_alu_data;
            2'b10:   w_src = i_pc_four;
            default: w_src = (AUX_EN != 0) ? i_aux_data : '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_wren       = 1'b0;
        w_addr       = o_rd_addr;
        w_data       = o_rd_data;
        w_timeout    = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_wb_sel != 2'b00 || i_ld_valid) begin
                        w_commit = 1'b1;
                        w_wren   = i_rd_wren && (i_rd_addr != 5'd0);
                        w_addr   = i_rd_addr;
                        w_data   = w_src;
                    end else begin
                        w_latch      = 1'b1;
                        w_next_state = S_WAIT_LD;
                    end
                end
            end
            S_WAIT_LD: begin
                if (i_ld_valid) begin
                    w_commit     = 1'b1;
                    w_wren       = r_ld_wren;
                    w_addr       = r_ld_rd_addr;
                    w_data       = w_ld_fmt;
                    w_next_state = S_IDLE;
                end else if (r_cnt == LP_LAST) begin
                    w_commit     = 1'b1;
                    w_addr       = r_ld_rd_addr;
                    w_data       = '0;
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_ld_wren    <= 1'b0;
            r_ld_rd_addr <= 5'd0;
            r_ld_funct3  <= 3'd0;
            r_ld_lo      <= 2'd0;
            o_rd_wren    <= 1'b0;
            o_rd_addr    <= 5'd0;
            o_rd_data    <= '0;
            o_ld_timeout <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            o_rd_wren    <= w_wren;
            o_ld_timeout <= w_timeout;
            if (w_commit) begin
                o_rd_addr <= w_addr;
                o_rd_data <= w_data;
            end
            if (w_latch) begin
                r_cnt        <= 8'd0;
                r_ld_wren    <= i_rd_wren && (i_rd_addr != 5'd0);
                r_ld_rd_addr <= i_rd_addr;
                r_ld_funct3  <= i_ld_funct3;
                r_ld_lo      <= i_ld_addr_lo;
            end else if (r_state == S_WAIT_LD) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of single-cycle commits plus hand-written
// delayed-load, timeout and reset-abort sequences, checked via an expected queue.
module tb_wb_stage;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic [1:0]  i_wb_sel;
    logic        i_rd_wren;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_alu_data, i_pc_four, i_aux_data, i_ld_data;
    logic [2:0]  i_ld_funct3;
    logic [1:0]  i_ld_addr_lo;
    logic        i_ld_valid;
    logic        o_ready, o_rd_wren, o_ld_timeout, o_dbg_state;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        z_ready, z_rd_wren, z_ld_timeout, z_dbg_state;
    logic [4:0]  z_rd_addr;
    logic [31:0] z_rd_data;

    int total = 0;
    int bad   = 0;
    logic [37:0] exp_q[$];
    logic [31:0] exp0_q[$];

    localparam logic [31:0] W = 32'h80FF_7F01;

    wb_stage #(.XLEN(32), .TIMEOUT(4), .AUX_EN(1)) u_dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_wb_sel(i_wb_sel), .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr),
        .i_alu_data(i_alu_data), .i_pc_four(i_pc_four), .i_aux_data(i_aux_data),
        .i_ld_funct3(i_ld_funct3), .i_ld_addr_lo(i_ld_addr_lo), .i_ld_valid(i_ld_valid),
        .i_ld_data(i_ld_data), .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr),
        .o_rd_data(o_rd_data), .o_ld_timeout(o_ld_timeout), .o_dbg_state(o_dbg_state)
    );

    wb_stage #(.XLEN(32), .TIMEOUT(4), .AUX_EN(0)) u_dut0 (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(z_ready),
        .i_wb_sel(i_wb_sel), .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr),
        .i_alu_data(i_alu_data), .i_pc_four(i_pc_four), .i_aux_data(i_aux_data),
        .i_ld_funct3(i_ld_funct3), .i_ld_addr_lo(i_ld_addr_lo), .i_ld_valid(i_ld_valid),
        .i_ld_data(i_ld_data), .o_rd_wren(z_rd_wren), .o_rd_addr(z_rd_addr),
        .o_rd_data(z_rd_data), .o_ld_timeout(z_ld_timeout), .o_dbg_state(z_dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  sel;
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] alu, pc4, aux;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] w;
        logic        exp_wren;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load formatter built from shifts and masks.
    function automatic logic [31:0] fmt_model(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lo);
        logic [31:0] b, h;
        b = (w >> (8 * int'(lo))) & 32'h0000_00FF;
        h = (w >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
        if (f3 == 3'b000) return b[7] ? (b | 32'hFFFF_FF00) : b;
        if (f3 == 3'b100) return b;
        if (f3 == 3'b001) return h[15] ? (h | 32'hFFFF_0000) : h;
        if (f3 == 3'b101) return h;
        return w;
    endfunction

    function automatic vec_t mk(input logic [1:0] sel, input logic wren, input logic [4:0] addr,
                                input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [31:0] aux, input logic [2:0] f3,
                                input logic [1:0] lo, input logic [31:0] w,
                                input logic [31:0] exp_data);
        vec_t v;
        v.sel = sel; v.wren = wren; v.addr = addr; v.alu = alu; v.pc4 = pc4; v.aux = aux;
        v.f3 = f3; v.lo = lo; v.w = w;
        v.exp_wren = wren && (addr != 5'd0);
        v.exp_addr = addr;
        v.exp_data = exp_data;
        return v;
    endfunction

    // driver: present one instruction (same-cycle load data) and queue its expectation
    task automatic drive_vec(input vec_t v);
        @(negedge clk);
        i_valid = 1'b1; i_wb_sel = v.sel; i_rd_wren = v.wren; i_rd_addr = v.addr;
        i_alu_data = v.alu; i_pc_four = v.pc4; i_aux_data = v.aux;
        i_ld_funct3 = v.f3; i_ld_addr_lo = v.lo; i_ld_data = v.w;
        i_ld_valid = (v.sel == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
        exp_q.push_back({v.exp_wren, v.exp_addr, v.exp_data});
        exp0_q.push_back((v.sel == 2'b11) ? 32'h0 : v.exp_data);
    endtask

    // monitor: one registered commit expected right after the accepting edge
    task automatic check_commit(input string name);
        logic [37:0] e;
        logic [31:0] e0;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e  = exp_q.pop_front();
            e0 = exp0_q.pop_front();
            chk(name, {o_rd_wren, o_rd_addr, o_rd_data}, e);
            chk({name, "_aux0"}, {6'd0, z_rd_data}, {6'd0, e0});
        end
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_ld_valid = 1'b0;
    endtask

    task automatic present_load(input logic [4:0] addr, input logic [2:0] f3,
                                input logic [1:0] lo);
        @(negedge clk);
        i_valid = 1'b1; i_wb_sel = 2'b00; i_rd_wren = 1'b1; i_rd_addr = addr;
        i_ld_funct3 = f3; i_ld_addr_lo = lo; i_ld_valid = 1'b0; i_ld_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        @(negedge clk);
        // scramble live fields so only the latched copies can give the right format
        i_valid = 1'b0; i_ld_funct3 = 3'b010; i_ld_addr_lo = 2'd1; i_rd_addr = 5'd31;
    endtask

    initial begin
        vec_t v;
        logic [31:0] ed;
        i_reset = 1'b1; i_valid = 1'b0; i_wb_sel = 2'b01; i_rd_wren = 1'b0; i_rd_addr = 5'd0;
        i_alu_data = 32'h0; i_pc_four = 32'h0; i_aux_data = 32'h0; i_ld_data = 32'h0;
        i_ld_funct3 = 3'd0; i_ld_addr_lo = 2'd0; i_ld_valid = 1'b0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_rd_wren, o_rd_addr, o_rd_data}, 38'd0);
        chk("reset_timeout", {37'd0, o_ld_timeout}, 38'd0);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("reset_ready", {37'd0, o_ready}, 38'd1);

        // vector table
        tbl.push_back(mk(2'b01, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h1234_5678));
        tbl.push_back(mk(2'b10, 1'b1, 5'd6, 32'h0, 32'h0000_0104, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0000_0104));
        tbl.push_back(mk(2'b11, 1'b1, 5'd7, 32'h0, 32'h0, 32'hCAFE_0000, 3'd0, 2'd0, 32'h0, 32'hCAFE_0000));
        tbl.push_back(mk(2'b01, 1'b1, 5'd0, 32'h5555_AAAA, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h5555_AAAA));
        tbl.push_back(mk(2'b01, 1'b0, 5'd9, 32'h0BAD_F00D, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0BAD_F00D));
        tbl.push_back(mk(2'b00, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0, 3'b000, 2'd3, W, 32'hFFFF_FF80));
        tbl.push_back(mk(2'b00, 1'b1, 5'd2, 32'h0, 32'h0, 32'h0, 3'b100, 2'd1, W, 32'h0000_007F));
        tbl.push_back(mk(2'b00, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 3'b001, 2'd2, W, 32'hFFFF_80FF));
        tbl.push_back(mk(2'b00, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0, 3'b101, 2'd0, W, 32'h0000_7F01));
        tbl.push_back(mk(2'b00, 1'b1, 5'd8, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0, W, 32'h80FF_7F01));
        tbl.push_back(mk(2'b00, 1'b1, 5'd10, 32'h0, 32'h0, 32'h0, 3'b001, 2'd3, W, 32'hFFFF_80FF));
        tbl.push_back(mk(2'b00, 1'b1, 5'd11, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, W, 32'h0000_0001));
        tbl.push_back(mk(2'b00, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0, 3'b011, 2'd2, W, 32'h80FF_7F01));
        for (int i = 0; i < 24; i++) begin
            v = mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), $urandom, 32'h0);
            case (v.sel)
                2'b00:   ed = fmt_model(v.w, v.f3, v.lo);
                2'b01:   ed = v.alu;
                2'b10:   ed = v.pc4;
                default: ed = v.aux;
            endcase
            v.exp_data = ed;
            tbl.push_back(v);
        end
        foreach (tbl[i]) begin
            drive_vec(tbl[i]);
            check_commit($sformatf("vec%0d", i));
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("idle_no_write", {37'd0, o_rd_wren}, 38'd0);

        // delayed load: response in the third wait cycle
        present_load(5'd20, 3'b000, 2'd3);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("dly_ready_c%0d", c), {36'd0, o_ready, o_rd_wren}, 38'd0);
            if (c == 3) begin
                @(negedge clk);
                i_ld_valid = 1'b1; i_ld_data = W;
                exp_q.push_back({1'b1, 5'd20, 32'hFFFF_FF80});
                exp0_q.push_back(32'hFFFF_FF80);
            end
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        check_commit("dly_commit");
        chk("dly_ready_back", {37'd0, o_ready}, 38'd1);
        drive_vec(mk(2'b01, 1'b1, 5'd21, 32'hA5A5_0001, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 32'hA5A5_0001));
        check_commit("dly_next");
        @(negedge clk);
        idle_inputs();

        // response in the last allowed wait cycle beats the timeout
        present_load(5'd22, 3'b101, 2'd2);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
        end
        chk("last_ready", {37'd0, o_ready}, 38'd0);
        @(negedge clk);
        i_ld_valid = 1'b1; i_ld_data = W;
        exp_q.push_back({1'b1, 5'd22, 32'h0000_80FF});
        exp0_q.push_back(32'h0000_80FF);
        check_commit("last_commit");
        chk("last_no_timeout", {37'd0, o_ld_timeout}, 38'd0);
        @(negedge clk);
        idle_inputs();

        // timeout: no response
        present_load(5'd23, 3'b010, 2'd0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_wait_c%0d", c), {35'd0, o_ready, o_rd_wren, o_ld_timeout}, 38'd0);
            @(posedge clk);
            #1;
        end
        chk("to_pulse", {35'd0, o_ld_timeout, o_rd_wren, o_ready}, {35'd0, 3'b101});
        chk("to_data_zero", {6'd0, o_rd_data}, 38'd0);
        @(negedge clk);
        i_ld_valid = 1'b1; i_ld_data = W;
        @(posedge clk);
        #1;
        chk("to_late_ignored", {36'd0, o_rd_wren, o_ld_timeout}, 38'd0);
        @(negedge clk);
        idle_inputs();

        // reset while waiting aborts the load
        drive_vec(mk(2'b01, 1'b1, 5'd24, 32'h7777_1111, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h7777_1111));
        check_commit("pre_rst");
        @(negedge clk);
        idle_inputs();
        present_load(5'd25, 3'b010, 2'd0);
        i_reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {o_rd_wren, o_rd_addr, o_rd_data}, 38'd0);
        chk("rst_mid_flags", {36'd0, o_ld_timeout, o_ready}, 38'd1);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        i_ld_valid = 1'b1; i_ld_data = W;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_after_c%0d", c), {35'd0, o_rd_wren, o_ld_timeout, o_ready}, 38'd1);
        end

        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: %0d expectations left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
